multicycle_adder: RTL and testbench



---
 rtl/multicycle_adder.sv | 140 ++++++++++++++
 tb/tb_multicycle_adder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_adder.sv
// multicycle_adder: WIDTH-bit adder that processes SLICE bits per clock with a
// registered carry between slices. Optional macro: MULTICYCLE_ADDER_SUBTRACT_EN.
module multicycle_adder #(
   parameter int WIDTH = 32,
   parameter int SLICE = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carryin,
`ifdef MULTICYCLE_ADDER_SUBTRACT_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carryout,
   output logic             overflow
);

   localparam int NSLICE = WIDTH / SLICE;
   localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

   if ((WIDTH % SLICE) != 0 || SLICE < 1) begin : g_bad_slice
      $error("multicycle_adder: WIDTH must be a multiple of SLICE");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nx;
   logic [CW-1:0]     cnt;
   logic [WIDTH-1:0]  a_q;
   logic [WIDTH-1:0]  b_q;
   logic              carry_q;
   logic [WIDTH-1:0]  sum_q;
   logic              cout_q;
   logic              ovf_q;

   logic              accept;
   logic              last;
   logic [WIDTH-1:0]  b_eff;
   logic              cin_eff;
   int                base;
   logic [SLICE-1:0]  a_s;
   logic [SLICE-1:0]  b_s;
   logic [SLICE-1:0]  s_s;
   logic              c_s;
   logic              msb_cin;

   // Subtraction is folded into the operand/carry captured at acceptance.
`ifdef MULTICYCLE_ADDER_SUBTRACT_EN
   assign b_eff   = sub ? ~b : b;
   assign cin_eff = sub ? 1'b1 : carryin;
`else
   assign b_eff   = b;
   assign cin_eff = carryin;
`endif

   assign accept = in_valid && in_ready;
   assign last   = (cnt == LAST);

   // Add the current slice selected by the counter, plus the carry register.
   always_comb begin
      base    = int'(cnt) * SLICE;
      a_s     = SLICE'(a_q >> base);
      b_s     = SLICE'(b_q >> base);
      {c_s, s_s} = {1'b0, a_s} + {1'b0, b_s}
                 + {{SLICE{1'b0}}, carry_q};
      msb_cin = a_s[SLICE-1] ^ b_s[SLICE-1] ^ s_s[SLICE-1];
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   // Next state and handshake outputs.
   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = reset_n;
            if (accept) state_nx = RUN;
         end
         RUN: begin
            if (last) state_nx = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Operand capture, slice counter, carry ripple and result registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (state == IDLE) begin
         if (accept) begin
            a_q     <= a;
            b_q     <= b_eff;
            carry_q <= cin_eff;
            cnt     <= '0;
         end
      end else if (state == RUN) begin
         sum_q[base +: SLICE] <= s_s;
         carry_q <= c_s;
         cnt     <= cnt + 1'b1;
         if (last) begin
            cout_q <= c_s;
            ovf_q  <= msb_cin ^ c_s;
         end
      end
   end

   assign sum      = sum_q;
   assign carryout = cout_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_multicycle_adder.sv
// Scoreboard bench for multicycle_adder (WIDTH=32, SLICE=8).
// Define MULTICYCLE_ADDER_SUBTRACT_EN to also exercise subtraction.
module tb_multicycle_adder;

   localparam int W  = 32;
   localparam int NS = 4;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          carryin;
   logic          sub;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  sum;
   logic          carryout;
   logic          overflow;

   typedef struct packed {
      logic [W-1:0] s;
      logic         c;
      logic         v;
   } exp_t;

   exp_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;
   int   acc_cyc = 0;
   logic prev_valid = 1'b0;

   multicycle_adder #(.WIDTH(W), .SLICE(8)) dut (
      .clk(clk),
      .reset_n(reset_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .a(a),
      .b(b),
      .carryin(carryin),
`ifdef MULTICYCLE_ADDER_SUBTRACT_EN
      .sub(sub),
`endif
      .out_valid(out_valid),
      .out_ready(out_ready),
      .sum(sum),
      .carryout(carryout),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Monitor: handshake completes on the next rising edge.
   always @(negedge clk) begin
      if (reset_n && out_valid && !prev_valid)
         chk("latency", 64'(cyc - acc_cyc), 64'(NS));
      if (reset_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_output", 64'(1), 64'(0));
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("sum", 64'(sum), 64'(e.s));
            chk("carryout", 64'(carryout), 64'(e.c));
            chk("overflow", 64'(overflow), 64'(e.v));
         end
      end
      prev_valid = reset_n && out_valid;
   end

   // Present operands, wait (bounded) for acceptance, optionally log expectation.
   task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic ic, input logic is, input bit push,
                        input exp_t e);
      int n;
      n = 0;
      a = ia; b = ib; carryin = ic; sub = is;
      in_valid = 1'b1;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) chk("accept_timeout", 64'(0), 64'(1));
      if (push) exp_q.push_back(e);
      @(posedge clk); #1;
      acc_cyc = cyc;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'(0));
   endtask

   initial begin
      exp_t held;
      logic [W-1:0] sum_held;
      reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; carryin = 1'b0; sub = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", 64'(in_ready), 64'(0));
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_sum", 64'(sum), 64'(0));
      chk("rst_cout_ovf", 64'({carryout, overflow}), 64'(0));
      reset_n = 1'b1;
      #1;
      chk("idle_in_ready", 64'(in_ready), 64'(1));

      issue(32'h00000001, 32'h00000001, 1'b0, 1'b0, 1, '{32'h00000002, 1'b0, 1'b0});
      drain();
      issue(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1, '{32'h00000000, 1'b1, 1'b0});
      drain();
      issue(32'h7FFFFFFF, 32'h00000000, 1'b1, 1'b0, 1, '{32'h80000000, 1'b0, 1'b1});
      drain();
      issue(32'h80000000, 32'h80000000, 1'b0, 1'b0, 1, '{32'h00000000, 1'b1, 1'b1});
      drain();
      issue(32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 1, '{32'hACF13568, 1'b0, 1'b0});
      drain();
      issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1, '{32'hFFFFFFFF, 1'b1, 1'b0});
      drain();

      // Backpressure: result held, new operands ignored.
      out_ready = 1'b0;
      held = '{32'h000000FF, 1'b0, 1'b0};
      issue(32'h00000080, 32'h0000007F, 1'b0, 1'b0, 1, held);
      repeat (NS) @(posedge clk);
      #1;
      sum_held = sum;
      a = 32'hDEADBEEF; b = 32'h11111111; in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         chk("hold_out_valid", 64'(out_valid), 64'(1));
         chk("hold_in_ready", 64'(in_ready), 64'(0));
         chk("hold_sum", 64'(sum), 64'(held.s));
         @(posedge clk); #1;
      end
      chk("hold_sum_end", 64'(sum), 64'(sum_held));
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("idle_after_hs", 64'({in_ready, out_valid}), 64'(2'b10));
      chk("hold_queue_empty", 64'(exp_q.size()), 64'(0));
      chk("sum_kept_after_hs", 64'(sum), 64'(held.s));

      // Reset during the second RUN cycle discards the operation.
      issue(32'h00000001, 32'h00000002, 1'b0, 1'b0, 0, '0);
      @(posedge clk); #1;
      reset_n = 1'b0;
      @(posedge clk); #1;
      chk("midrun_out_valid", 64'(out_valid), 64'(0));
      chk("midrun_sum", 64'(sum), 64'(0));
      chk("midrun_in_ready", 64'(in_ready), 64'(0));
      reset_n = 1'b1;
      #1;
      chk("release_in_ready", 64'(in_ready), 64'(1));
      issue(32'h00000003, 32'h00000004, 1'b0, 1'b0, 1, '{32'h00000007, 1'b0, 1'b0});
      drain();

`ifdef MULTICYCLE_ADDER_SUBTRACT_EN
      issue(32'h00000005, 32'h00000007, 1'b1, 1'b1, 1, '{32'hFFFFFFFE, 1'b0, 1'b0});
      drain();
      issue(32'h80000000, 32'h00000001, 1'b0, 1'b1, 1, '{32'h7FFFFFFF, 1'b1, 1'b1});
      drain();
      issue(32'h00000009, 32'h00000004, 1'b1, 1'b0, 1, '{32'h0000000E, 1'b0, 1'b0});
      drain();
`endif

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1);
   end

endmodule
